// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state type and constants for the note-speed path
package game_pkg;

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    SETTLE      = 2'd1,
    WAIT_UNLOCK = 2'd2,
    RAMP        = 2'd3
  } spd_state_t;

  localparam int         SPEED_MIN  = 1;
  localparam logic [3:0] DIGIT_ZERO = 4'd0;

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser plus settle timer with one-cycle accept pulse
module switch_debouncer #(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sel_sync,
  output logic             accept
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_eff;
  logic             settled;
  logic             changed;

  // A change restarts the count in the same cycle it is seen, so the
  // accepted value has been stable for exactly SETTLE_CYCLES cycles.
  assign changed = (sel_sync != prev);
  assign cnt_eff = changed ? '0 : cnt;
  assign accept  = (changed || !settled) && (cnt_eff == CNT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= '0;
      sel_sync <= '0;
      prev     <= '0;
      cnt      <= '0;
      settled  <= 1'b1;
    end else begin
      meta     <= din;
      sel_sync <= meta;
      prev     <= sel_sync;
      if (accept) begin
        settled <= 1'b1;
        cnt     <= '0;
      end else if (changed) begin
        settled <= 1'b0;
        cnt     <= CNT_W'(1);
      end else if (!settled) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/speed_controller.sv
// rtl/speed_controller.sv - debounced, lock-aware note-fall speed selector with per-frame ramp
module speed_controller
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = 3,
  parameter int SEL_W         = 2,
  parameter int LVL_W         = 4,
  parameter int SETTLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sw_speed,
  input  logic             lock,
  input  logic             frame_tick,
  output logic [LVL_W-1:0] note_speed,
  output logic [LVL_W-1:0] target_speed,
  output logic             speed_changed,
  output logic             pending,
  output logic [3:0]       digit_hi,
  output logic [3:0]       digit_lo
);

  function automatic logic [LVL_W-1:0] level_map(input logic [SEL_W-1:0] s);
    logic [LVL_W-1:0] l;
    l = LVL_W'(s) + LVL_W'(1);
    return (l > LVL_W'(NUM_LEVELS)) ? LVL_W'(NUM_LEVELS) : l;
  endfunction

  logic [SEL_W-1:0] sel_s;
  logic             accept;
  logic [LVL_W-1:0] mapped;
  logic [LVL_W-1:0] target_n;
  logic [LVL_W-1:0] note_n;
  logic             step;
  spd_state_t       state;
  spd_state_t       state_n;

  switch_debouncer #(
    .WIDTH        (SEL_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_sw_deb (
    .clk     (clk),
    .reset   (reset),
    .din     (sw_speed),
    .sel_sync(sel_s),
    .accept  (accept)
  );

  assign mapped   = level_map(sel_s);
  assign digit_lo = DIGIT_ZERO;

  // Acceptance overrides every state so a late-settling selection is never lost.
  always_comb begin
    state_n  = state;
    target_n = target_speed;
    note_n   = note_speed;
    step     = 1'b0;
    if (accept) begin
      target_n = mapped;
      if (mapped == note_speed) state_n = HOLD;
      else if (lock)            state_n = WAIT_UNLOCK;
      else                      state_n = RAMP;
    end else begin
      case (state)
        HOLD: begin
          if (mapped != target_speed)  state_n = SETTLE;
          else if (pending && !lock)   state_n = RAMP;
        end
        SETTLE: state_n = SETTLE;
        WAIT_UNLOCK: begin
          if (mapped != target_speed) state_n = SETTLE;
          else if (!lock)             state_n = RAMP;
        end
        RAMP: begin
          if (mapped != target_speed)           state_n = SETTLE;
          else if (lock)                        state_n = WAIT_UNLOCK;
          else if (note_speed == target_speed)  state_n = HOLD;
          else if (frame_tick) begin
            step   = 1'b1;
            note_n = (target_speed > note_speed) ? note_speed + LVL_W'(1)
                                                 : note_speed - LVL_W'(1);
            if (note_n == target_speed) state_n = HOLD;
          end
        end
        default: state_n = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HOLD;
      target_speed  <= LVL_W'(SPEED_MIN);
      note_speed    <= LVL_W'(SPEED_MIN);
      speed_changed <= 1'b0;
      pending       <= 1'b0;
      digit_hi      <= 4'(SPEED_MIN);
    end else begin
      state         <= state_n;
      target_speed  <= target_n;
      note_speed    <= note_n;
      speed_changed <= step;
      pending       <= (target_n != note_n);
      digit_hi      <= 4'(note_n);
    end
  end

endmodule

// File: tb/tb_speed_controller.sv
// tb/tb_speed_controller.sv - randomized and directed checks of speed_controller against a rule-based model
module tb_speed_controller;

  localparam int SETTLE = 4;
  localparam int NLVL   = 3;
  localparam int HIST   = SETTLE + 5;

  logic       clk;
  logic       reset;
  logic [1:0] sw_speed;
  logic       lock;
  logic       frame_tick;
  logic [3:0] note_speed;
  logic [3:0] target_speed;
  logic       speed_changed;
  logic       pending;
  logic [3:0] digit_hi;
  logic [3:0] digit_lo;

  speed_controller #(
    .NUM_LEVELS   (NLVL),
    .SEL_W        (2),
    .LVL_W        (4),
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_speed     (sw_speed),
    .lock         (lock),
    .frame_tick   (frame_tick),
    .note_speed   (note_speed),
    .target_speed (target_speed),
    .speed_changed(speed_changed),
    .pending      (pending),
    .digit_hi     (digit_hi),
    .digit_lo     (digit_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int hist[HIST];
  int m_target = 1;
  int m_live   = 1;
  bit prev_lock = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lvl(input int s);
    return (s + 1 > NLVL) ? NLVL : s + 1;
  endfunction

  // One clock: capture what the DUT saw at the edge, advance the model, compare.
  task automatic cycle();
    bit a_tick, a_lock, a_reset, acc, quiet, must, no_step;
    int a_sw;
    @(posedge clk);
    a_tick  = frame_tick;
    a_lock  = lock;
    a_reset = reset;
    a_sw    = int'(sw_speed);
    #1;
    if (a_reset) begin
      foreach (hist[i]) hist[i] = 0;
      m_target  = 1;
      m_live    = 1;
      prev_lock = 1'b1;
      check("reset_pulse", int'(speed_changed), 0);
    end else begin
      for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = a_sw;
      acc = (hist[SETTLE+2] != hist[2]);
      for (int i = 3; i <= SETTLE + 1; i++) if (hist[i] != hist[2]) acc = 1'b0;
      quiet = 1'b1;
      for (int i = 1; i < HIST; i++) if (hist[i] != hist[0]) quiet = 1'b0;
      no_step = !a_tick || a_lock || acc || (m_live == m_target);
      must    = a_tick && !a_lock && !prev_lock && quiet && (m_live != m_target);
      if (no_step)   check("no_step", int'(speed_changed), 0);
      else if (must) check("step", int'(speed_changed), 1);
      if (speed_changed && m_live != m_target) m_live += (m_target > m_live) ? 1 : -1;
      if (acc) m_target = lvl(hist[2]);
      prev_lock = a_lock;
    end
    check("target", int'(target_speed), m_target);
    check("note", int'(note_speed), m_live);
    check("pending", int'(pending), int'(m_target != m_live));
    check("digit_hi", int'(digit_hi), m_live);
    check("digit_lo", int'(digit_lo), 0);
    if (speed_changed) pulses++;
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      frame_tick = (period > 0) && (i % period == period - 1);
      cycle();
    end
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; lock = 1'b0; frame_tick = 1'b0; sw_speed = 2'd0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    bit seen;
    foreach (hist[i]) hist[i] = 0;
    reset = 1'b1; lock = 1'b0; frame_tick = 1'b0; sw_speed = 2'd0;

    do_reset();
    p0 = pulses;
    run(20, 0);
    check("idle_pulses", pulses - p0, 0);
    check("idle_note", int'(note_speed), 1);
    check("idle_target", int'(target_speed), 1);
    check("idle_digit_hi", int'(digit_hi), 1);
    check("idle_digit_lo", int'(digit_lo), 0);

    do_reset();
    sw_speed = 2'd2;
    run(5, 0);
    check("latency_before", int'(target_speed), 1);
    run(1, 0);
    check("latency_at", int'(target_speed), 3);
    p0 = pulses;
    run(30, 10);
    check("ramp_pulses", pulses - p0, 2);
    check("ramp_note", int'(note_speed), 3);
    check("ramp_pending", int'(pending), 0);

    do_reset();
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      sw_speed = 2'd1; run(2, 3);
      sw_speed = 2'd0; run(2, 3);
    end
    run(20, 3);
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_target", int'(target_speed), 1);

    do_reset();
    lock = 1'b1; sw_speed = 2'd1;
    run(10, 0);
    check("locked_target", int'(target_speed), 2);
    check("locked_pending", int'(pending), 1);
    run(50, 10);
    check("locked_note", int'(note_speed), 1);
    lock = 1'b0;
    run(10, 10);
    check("unlock_note", int'(note_speed), 2);

    do_reset();
    sw_speed = 2'd2;
    run(6, 0);
    p0 = pulses;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      frame_tick = (i % 10 == 9);
      cycle();
      seen = (pulses != p0);
    end
    frame_tick = 1'b0;
    check("first_step_seen", int'(seen), 1);
    lock = 1'b1;
    run(50, 10);
    check("frozen_note", int'(note_speed), 2);
    lock = 1'b0;
    run(10, 10);
    check("resumed_note", int'(note_speed), 3);

    do_reset();
    lock = 1'b1; sw_speed = 2'd2;
    run(10, 0);
    check("wait_target", int'(target_speed), 3);
    check("wait_pending", int'(pending), 1);
    reset = 1'b1;
    cycle();
    check("rst_target", int'(target_speed), 1);
    check("rst_note", int'(note_speed), 1);
    check("rst_pending", int'(pending), 0);
    check("rst_digit_hi", int'(digit_hi), 1);
    check("rst_changed", int'(speed_changed), 0);
    reset = 1'b0; lock = 1'b0; sw_speed = 2'd0;

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 11) == 0) sw_speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 23) == 0) lock = ~lock;
      frame_tick = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end

    reset = 1'b0; lock = 1'b0;
    run(80, 4);
    check("final_target", int'(target_speed), lvl(int'(sw_speed)));
    check("final_note", int'(note_speed), lvl(int'(sw_speed)));
    check("final_pending", int'(pending), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
